// File: rtl/path_stepper_pkg.sv
// Shared definitions for the path stepper and related pointer/brush controllers:
// coordinate width, direction bit positions and FSM encoding.
package path_stepper_pkg;
  localparam int COORD_W   = 9;

  localparam int DIR_LEFT  = 3;
  localparam int DIR_UP    = 2;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/path_stepper_step_timer.sv
// Loadable down-counter that holds at zero; zero flag is combinational from the count.
module step_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 count <= '0;
    else if (load)             count <= load_val;
    else if (en && count != 0) count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/path_stepper.sv
// Walks a pointer toward a latched target, one registered direction pulse every
// STEP_DIV cycles, using curX/curY fed back from the external position register.
module path_stepper
  import path_stepper_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  coord_t       targetX,
  input  coord_t       targetY,
  input  coord_t       curX,
  input  coord_t       curY,
  output logic [3:0]   directions,
  output logic         busy,
  output logic         done,
  output logic [9:0]   step_count
);
  // First wait spans STEP_DIV cycles; later waits are one shorter because the
  // STEP cycle itself completes the STEP_DIV pulse period.
  localparam logic [7:0] RELOAD_START = 8'(STEP_DIV - 1);
  localparam logic [7:0] RELOAD_STEP  = 8'(STEP_DIV - 2);

  logic [1:0] state, nxt;
  coord_t     tX, tY;
  logic [3:0] step_dir;
  logic       at_target;
  logic       t_load, t_en, t_zero;
  logic [7:0] t_val;
  logic       issue;

  step_timer #(.W(8)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .en       (t_en),
    .load_val (t_val),
    .zero     (t_zero)
  );

  // At most one bit per axis by construction.
  always_comb begin
    step_dir = '0;
    if (curX > tX)      step_dir[DIR_LEFT]  = 1'b1;
    else if (curX < tX) step_dir[DIR_RIGHT] = 1'b1;
    if (curY > tY)      step_dir[DIR_UP]    = 1'b1;
    else if (curY < tY) step_dir[DIR_DOWN]  = 1'b1;
  end

  assign at_target = (step_dir == 4'b0000);
  assign issue     = (state == S_STEP) && !abort && !at_target;

  always_comb begin
    nxt    = state;
    t_load = 1'b0;
    t_en   = 1'b0;
    t_val  = RELOAD_START;
    case (state)
      S_IDLE: if (start) begin
        nxt    = S_WAIT;
        t_load = 1'b1;
      end
      S_WAIT: begin
        if (abort)       nxt  = S_IDLE;
        else if (t_zero) nxt  = S_STEP;
        else             t_en = 1'b1;
      end
      S_STEP: begin
        if (abort)          nxt = S_IDLE;
        else if (at_target) nxt = S_DONE;
        else begin
          nxt    = S_WAIT;
          t_load = 1'b1;
          t_val  = RELOAD_STEP;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tX         <= '0;
      tY         <= '0;
      directions <= 4'b0000;
      step_count <= '0;
    end else begin
      state      <= nxt;
      directions <= issue ? step_dir : 4'b0000;
      if (state == S_IDLE && start) begin
        tX         <= targetX;
        tY         <= targetY;
        step_count <= '0;
      end else if (issue && step_count != 10'd1023) begin
        step_count <= step_count + 10'd1;
      end
    end
  end

  assign busy = (state == S_WAIT) || (state == S_STEP);
  assign done = (state == S_DONE);
endmodule
